// File: rtl/sd_pio_clkgen.sv
// Avalon-MM PIO output port with a hardware SD card clock burst generator.
// Software loads a pulse count; the FSM emits that many divided clock pulses and flags done.
//   state | meaning
//   IDLE  | no burst in progress, sd_clk_out low
//   HIGH  | high phase of a pulse, phase counter running
//   LOW   | low phase of a pulse, remaining decremented at its end
module sd_pio_clkgen #(
    parameter int               WIDTH       = 1,
    parameter int               DIV_WIDTH   = 8,
    parameter int               CNT_WIDTH   = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             sd_clk_out,
    output logic             irq
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state, state_nxt;
    logic [DIV_WIDTH-1:0] divider, phase_cnt, phase_nxt;
    logic [CNT_WIDTH-1:0] remaining, rem_nxt, pulse_n;
    logic                 clk_nxt, done, done_set, irq_en, busy, wr, pulse_wr;

    assign wr       = chipselect & ~write_n;
    assign pulse_wr = wr && (address == 3'd4);
    assign pulse_n  = writedata[CNT_WIDTH-1:0];
    assign busy     = (state != IDLE);
    assign irq      = done & irq_en;

    always_comb begin
        state_nxt = state;
        phase_nxt = phase_cnt;
        rem_nxt   = remaining;
        clk_nxt   = sd_clk_out;
        done_set  = 1'b0;
        if (busy && pulse_wr && pulse_n == '0) begin
            // zero count while running aborts without touching done
            state_nxt = IDLE;
            phase_nxt = '0;
            rem_nxt   = '0;
            clk_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pulse_wr && pulse_n != '0) begin
                        state_nxt = HIGH;
                        rem_nxt   = pulse_n;
                        phase_nxt = divider;
                        clk_nxt   = 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_cnt == '0) begin
                        state_nxt = LOW;
                        phase_nxt = divider;
                        clk_nxt   = 1'b0;
                    end else begin
                        phase_nxt = phase_cnt - DIV_ONE;
                    end
                end
                LOW: begin
                    if (phase_cnt == '0) begin
                        if (remaining > CNT_ONE) begin
                            rem_nxt   = remaining - CNT_ONE;
                            state_nxt = HIGH;
                            phase_nxt = divider;
                            clk_nxt   = 1'b1;
                        end else begin
                            rem_nxt   = '0;
                            state_nxt = IDLE;
                            clk_nxt   = 1'b0;
                            done_set  = 1'b1;
                        end
                    end else begin
                        phase_nxt = phase_cnt - DIV_ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            remaining  <= '0;
            sd_clk_out <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase_cnt  <= phase_nxt;
            remaining  <= rem_nxt;
            sd_clk_out <= clk_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= RESET_VALUE;
            divider  <= '0;
            irq_en   <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (wr) begin
                case (address)
                    3'd0:    out_port <= writedata[WIDTH-1:0];
                    3'd1:    out_port <= out_port | writedata[WIDTH-1:0];
                    3'd2:    out_port <= out_port & ~writedata[WIDTH-1:0];
                    3'd3:    divider  <= writedata[DIV_WIDTH-1:0];
                    3'd6:    irq_en   <= writedata[0];
                    default: ;
                endcase
            end
            // a completion on the same edge as a W1C keeps done set
            if (done_set)
                done <= 1'b1;
            else if (wr && address == 3'd5 && writedata[1])
                done <= 1'b0;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0, 3'd1, 3'd2: readdata = 32'(out_port);
            3'd3:             readdata = 32'(divider);
            3'd4:             readdata = 32'(remaining);
            3'd5:             readdata = {30'b0, done, busy};
            3'd6:             readdata = {31'b0, irq_en};
            default:          readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_sd_pio_clkgen.sv
// Bench for sd_pio_clkgen: a phase-duration model checked every cycle, plus
// directed scenarios with hand-computed timing and register values.
module tb_sd_pio_clkgen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [3:0]  out_port;
    logic        sd_clk_out;
    logic        irq;

    sd_pio_clkgen #(
        .WIDTH(4), .DIV_WIDTH(8), .CNT_WIDTH(16), .RESET_VALUE(4'hA)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .sd_clk_out(sd_clk_out), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // model: a burst is a sequence of phases, each divider+1 cycles long
    logic [3:0] m_out = 4'hA;
    int         m_div = 0;
    int         m_rem = 0;
    int         m_left = 0;
    bit         m_high = 0, m_busy = 0, m_done = 0, m_ien = 0;

    always @(posedge clk or negedge reset_n) begin
        bit wr, dset;
        int n;
        if (!reset_n) begin
            m_out = 4'hA; m_div = 0; m_rem = 0; m_left = 0;
            m_high = 0; m_busy = 0; m_done = 0; m_ien = 0;
        end else begin
            wr = chipselect && !write_n;
            n = int'(writedata[15:0]);
            dset = 0;
            if (m_busy) begin
                if (wr && address == 3'd4 && n == 0) begin
                    m_busy = 0; m_high = 0; m_rem = 0;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_high) begin
                            m_high = 0; m_left = m_div + 1;
                        end else begin
                            m_rem = m_rem - 1;
                            if (m_rem == 0) begin
                                m_busy = 0; dset = 1;
                            end else begin
                                m_high = 1; m_left = m_div + 1;
                            end
                        end
                    end
                end
            end else if (wr && address == 3'd4 && n != 0) begin
                m_busy = 1; m_high = 1; m_rem = n; m_left = m_div + 1;
            end
            if (wr) begin
                case (address)
                    3'd0: m_out = writedata[3:0];
                    3'd1: m_out = m_out | writedata[3:0];
                    3'd2: m_out = m_out & ~writedata[3:0];
                    3'd3: m_div = int'(writedata[7:0]);
                    3'd5: if (writedata[1]) m_done = 0;
                    3'd6: m_ien = writedata[0];
                    default: ;
                endcase
            end
            if (dset) m_done = 1;
        end
    end

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2: return {28'd0, m_out};
            3'd3:             return 32'(m_div);
            3'd4:             return 32'(m_rem);
            3'd5:             return {30'd0, m_done, m_busy};
            3'd6:             return {31'd0, m_ien};
            default:          return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        chk("sd_clk_out", {31'd0, sd_clk_out}, {31'd0, m_high});
        chk("irq", {31'd0, irq}, {31'd0, m_done & m_ien});
        chk("out_port", {28'd0, out_port}, {28'd0, m_out});
        chk("readdata", readdata, model_read(address));
    end

    // cycle numbers at which sd_clk_out changed level
    int   cyc = 0;
    int   chg[$];
    logic prev_clk = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (sd_clk_out !== prev_clk) chg.push_back(cyc);
        prev_clk = sd_clk_out;
    end

    // bus settings made here are sampled by the DUT on the following posedge
    task automatic bus(input logic [2:0] a, input logic [31:0] d, input bit we);
        @(posedge clk);
        #1;
        address = a;
        writedata = d;
        chipselect = we;
        write_n = !we;
    endtask

    initial begin
        int rems[$];
        int busy_cyc;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // reset values and readback
        @(negedge clk);
        chk("t1_out", {28'd0, out_port}, 32'hA);
        chk("t1_rd0", readdata, 32'hA);
        chk("t1_clk", {31'd0, sd_clk_out}, 32'd0);
        chk("t1_irq", {31'd0, irq}, 32'd0);
        bus(3'd5, 32'd0, 0);
        @(negedge clk);
        chk("t1_rd5", readdata, 32'd0);

        // DATA / SET / CLR
        bus(3'd0, 32'h0, 1);
        bus(3'd1, 32'h5, 1);
        bus(3'd2, 32'h1, 1);
        bus(3'd0, 32'h0, 0);
        @(negedge clk);
        chk("t2_out", {28'd0, out_port}, 32'h4);
        chk("t2_rd", readdata, 32'h4);
        bus(3'd0, 32'hFFFF_FFF0, 1);
        bus(3'd0, 32'h0, 0);
        @(negedge clk);
        chk("t2_out0", {28'd0, out_port}, 32'h0);
        chk("t2_rd0", readdata, 32'h0);

        // burst: divider 2, three pulses
        bus(3'd3, 32'd2, 1);
        bus(3'd4, 32'd3, 1);
        chg.delete();
        bus(3'd4, 32'd0, 0);
        busy_cyc = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (readdata != 0) busy_cyc++;
            if (rems.size() == 0 || rems[$] != int'(readdata)) rems.push_back(int'(readdata));
        end
        chk("t3_busy_cycles", 32'(busy_cyc), 32'd18);
        chk("t3_nrem", 32'(rems.size()), 32'd4);
        for (int i = 0; i < rems.size() && i < 4; i++)
            chk("t3_rem_seq", 32'(rems[i]), 32'(3 - i));
        chk("t3_nchg", 32'(chg.size()), 32'd6);
        for (int i = 1; i < chg.size(); i++)
            chk("t3_phase_len", 32'(chg[i] - chg[i-1]), 32'd3);
        bus(3'd5, 32'd0, 0);
        @(negedge clk);
        chk("t3_status", readdata, 32'd2);

        // irq and W1C, then W1C on the done-set edge
        bus(3'd6, 32'd1, 1);
        bus(3'd3, 32'd0, 1);
        bus(3'd5, 32'd2, 1);
        chg.delete();
        bus(3'd4, 32'd1, 1);
        bus(3'd5, 32'd0, 0);
        bus(3'd5, 32'd0, 0);
        bus(3'd5, 32'd0, 0);
        @(negedge clk);
        chk("t4_irq", {31'd0, irq}, 32'd1);
        chk("t4_status", readdata, 32'd2);
        chk("t4_nchg", 32'(chg.size()), 32'd2);
        if (chg.size() >= 2) chk("t4_high_len", 32'(chg[1] - chg[0]), 32'd1);
        bus(3'd5, 32'd2, 1);
        bus(3'd5, 32'd0, 0);
        @(negedge clk);
        chk("t4_irq_clr", {31'd0, irq}, 32'd0);
        chk("t4_status_clr", readdata, 32'd0);
        bus(3'd4, 32'd1, 1);
        bus(3'd5, 32'd0, 0);
        bus(3'd5, 32'd2, 1);
        bus(3'd5, 32'd0, 0);
        @(negedge clk);
        chk("t4_set_wins", readdata, 32'd2);
        chk("t4_set_wins_irq", {31'd0, irq}, 32'd1);
        bus(3'd5, 32'd2, 1);

        // ignored start and abort
        bus(3'd3, 32'd1, 1);
        bus(3'd4, 32'd10, 1);
        bus(3'd4, 32'd0, 0);
        bus(3'd4, 32'd0, 0);
        bus(3'd4, 32'd5, 1);
        bus(3'd4, 32'd0, 0);
        bus(3'd4, 32'd0, 0);
        @(negedge clk);
        chk("t5_rem_after_ignored", readdata, 32'd9);
        bus(3'd4, 32'd0, 0);
        bus(3'd4, 32'd0, 1);
        bus(3'd5, 32'd0, 0);
        @(negedge clk);
        chk("t5_abort_clk", {31'd0, sd_clk_out}, 32'd0);
        chk("t5_abort_status", readdata, 32'd0);
        bus(3'd4, 32'd0, 0);
        @(negedge clk);
        chk("t5_abort_rem", readdata, 32'd0);

        // divider change during the first high phase, then reset mid-burst
        bus(3'd3, 32'd1, 1);
        chg.delete();
        bus(3'd4, 32'd4, 1);
        bus(3'd3, 32'd3, 1);
        bus(3'd4, 32'd0, 0);
        repeat (12) @(negedge clk);
        chk("t6_nchg", 32'(chg.size() >= 3), 32'd1);
        if (chg.size() >= 3) begin
            chk("t6_first_high", 32'(chg[1] - chg[0]), 32'd2);
            chk("t6_next_low", 32'(chg[2] - chg[1]), 32'd4);
        end
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_rst_clk", {31'd0, sd_clk_out}, 32'd0);
        chk("t6_rst_out", {28'd0, out_port}, 32'hA);
        chk("t6_rst_irq", {31'd0, irq}, 32'd0);
        chk("t6_rst_rem", readdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_pio_clkgen.md
Name: sd_pio_clkgen

Overview:
Avalon-MM slave giving the Nios II a parametrised-width output port plus a hardware SD clock pulse generator. Software writes a pulse count instead of toggling the SD clock one write at a time. The divider is programmable, busy/done status is readable, and a completion interrupt is available. The block sits on the SD subsystem's system bus and drives the card clock plus auxiliary control bits such as CS and power enable.

Parameters:
WIDTH, 1, width of out_port (1..32).
DIV_WIDTH, 8, width of the clock half-period divider register.
CNT_WIDTH, 16, width of the pulse counter.
RESET_VALUE, 0, reset value of out_port (WIDTH bits).

Ports:
clk  in  1  system clock; all logic on posedge.
reset_n  in  1  asynchronous active-low reset.
address  in  3  register word address.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe.
writedata  in  32  write data.
readdata  out  32  read data, zero-extended.
out_port  out  WIDTH  general output bits.
sd_clk_out  out  1  generated SD clock, registered.
irq  out  1  completion interrupt, level.

Behaviour:
- Reset (async, reset_n=0): out_port=RESET_VALUE, sd_clk_out=0, divider=0, remaining=0, busy=0, done=0, irq_en=0, FSM=IDLE, irq=0.
- A write occurs on the edge where chipselect=1 and write_n=0. Reads are combinational with zero wait states: readdata is muxed by address, independent of chipselect. Unused upper bits and unmapped addresses read 0.
- addr 0 DATA (RW): write sets out_port=writedata[WIDTH-1:0].
- addr 1 SET (W; reads DATA): out_port |= writedata[WIDTH-1:0].
- addr 2 CLR (W; reads DATA): out_port &= ~writedata[WIDTH-1:0].
- addr 3 DIVIDER (RW): writedata[DIV_WIDTH-1:0]. Each clock phase lasts divider+1 clk cycles.
- addr 4 PULSE (W start/abort; R returns remaining).
- addr 5 STATUS (R): bit0=busy, bit1=done. Writing 1 to bit1 clears done (W1C); other bits are ignored.
- addr 6 CONTROL (RW): bit0=irq_en.
- FSM states are IDLE, HIGH and LOW.
  - IDLE -> HIGH: on a PULSE write with N!=0, where N=writedata[CNT_WIDTH-1:0]. On that edge: remaining=N, phase counter=divider, sd_clk_out=1 from the next cycle, busy=1.
  - HIGH: the phase counter decrements each cycle. At 0, go to LOW, sd_clk_out=0, reload the counter from the current divider.
  - LOW: at counter 0, remaining decrements. If the new remaining is !=0, go to HIGH (sd_clk_out=1, reload). Otherwise go to IDLE, busy=0, done=1 on the same edge.
- Nominal timing: N pulses give a busy time of 2*N*(divider+1) cycles and a 50% duty cycle.
- The divider is sampled at each phase load. A write while busy takes effect from the next phase, never mid-phase.
- PULSE write with N=0 in IDLE: no effect.
- PULSE write with N!=0 while busy: ignored.
- PULSE write with N=0 while busy is an abort: next cycle FSM=IDLE, sd_clk_out=0, remaining=0, busy=0, done unchanged.
- If a done-set and a W1C clear land on the same edge, set wins.
- Writes to DATA/SET/CLR are independent of the FSM and allowed while busy.
- irq = done & irq_en, registered or combinational from those registers, with no extra latency beyond done.
- Reset asserted mid-burst: immediate return to reset values, sd_clk_out low asynchronously.
- Counters never wrap: remaining stops at 0 and the phase counter reloads before underflow.

Test Plan:
1. Reset/readback, WIDTH=4, RESET_VALUE=4'hA: release reset -> out_port=4'hA, read addr0=32'hA, addr5=0, sd_clk_out=0, irq=0.
2. SET/CLR: write DATA=4'h0, SET 4'h5, CLR 4'h1 -> out_port=4'h4. Write writedata=32'hFFFFFFF0 to DATA -> out_port=0, readdata upper bits 0.
3. Burst: divider=2, PULSE=3 -> sd_clk_out high 3 cycles then low 3 cycles, 3 times. Busy lasts 18 cycles, done=1 on the busy-falling edge. Reading PULSE mid-burst gives 3,2,1 as each pulse completes.
4. IRQ/W1C: irq_en=1, burst N=1 divider=0 -> sd_clk_out 1 cycle high, 1 low, irq=1. Write STATUS=2 -> done=0, irq=0. Repeat with the clear landing on the done-set edge -> done stays 1.
5. Abort and ignored start: PULSE=10 divider=1, PULSE=5 at cycle 3 -> ignored, remaining still counts from 10. PULSE=0 at cycle 7 -> busy=0 and sd_clk_out=0 the next cycle, done=0.
6. Divider change mid-burst plus reset: divider=1, PULSE=4, write divider=3 during the first HIGH -> first HIGH lasts 2 cycles, subsequent phases 4 cycles. Assert reset_n=0 mid-burst -> all outputs return to reset values immediately.
